// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage MIPS core: tracks E/M/W destination records,
// chooses D-stage forward sources, raises stall, and interlocks the mult/div unit.
module hazard_sched #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic [4:0]  D_dst,
  input  logic [1:0]  D_tnew,
  input  logic        D_memsrc,
  input  logic        D_md_start,
  input  logic        D_md_div,
  input  logic        D_md_use,
  output logic        stall,
  output logic [31:0] D_FMUX1_slt,
  output logic [31:0] D_FMUX2_slt,
  output logic        md_busy
);

  localparam logic [4:0] MULT_CNT = 5'(MULT_LAT);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_LAT);

  // W's tnew and the md/div flags of M and W never influence any decision,
  // so only the fields that matter are carried past E.
  logic [4:0] e_dst, m_dst, w_dst;
  logic [1:0] e_tnew, m_tnew;
  logic       e_mem, m_mem, w_mem;
  logic       e_md, e_div;
  logic [4:0] md_cnt;

  logic [2:0] rs_res, rt_res;
  logic       md_stall;

  // Returns {stall, select} for one source operand; youngest match wins.
  function automatic logic [2:0] resolve(input logic [4:0] src, input logic [1:0] tuse);
    logic [1:0] e_eff;
    e_eff   = (e_tnew == 2'd0) ? 2'd1 : e_tnew;
    resolve = {1'b0, 2'd3};
    if (src != 5'd0) begin
      if (src == e_dst) begin
        resolve = {(e_eff > tuse), 2'd3};
      end else if (src == m_dst) begin
        if (m_tnew > tuse)
          resolve = {1'b1, 2'd3};
        else if (m_tnew == 2'd0 && !m_mem)
          resolve = {1'b0, 2'd0};
      end else if (src == w_dst) begin
        resolve = {1'b0, (w_mem ? 2'd2 : 2'd1)};
      end
    end
  endfunction

  always_comb begin
    rs_res      = resolve(D_rs, D_rs_tuse);
    rt_res      = resolve(D_rt, D_rt_tuse);
    md_busy     = (md_cnt != 5'd0);
    md_stall    = (D_md_use | D_md_start) & (md_busy | e_md);
    stall       = rs_res[2] | rt_res[2] | md_stall;
    D_FMUX1_slt = {30'd0, rs_res[1:0]};
    D_FMUX2_slt = {30'd0, rt_res[1:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_dst  <= '0;
      e_tnew <= '0;
      e_mem  <= 1'b0;
      e_md   <= 1'b0;
      e_div  <= 1'b0;
      m_dst  <= '0;
      m_tnew <= '0;
      m_mem  <= 1'b0;
      w_dst  <= '0;
      w_mem  <= 1'b0;
      md_cnt <= '0;
    end else begin
      w_dst  <= m_dst;
      w_mem  <= m_mem;
      m_dst  <= e_dst;
      m_tnew <= (e_tnew != 2'd0) ? e_tnew - 2'd1 : 2'd0;
      m_mem  <= e_mem;
      if (stall) begin
        e_dst  <= '0;
        e_tnew <= '0;
        e_mem  <= 1'b0;
        e_md   <= 1'b0;
        e_div  <= 1'b0;
      end else begin
        e_dst  <= D_dst;
        e_tnew <= D_tnew;
        e_mem  <= D_memsrc;
        e_md   <= D_md_start;
        e_div  <= D_md_div;
      end
      if (e_md)
        md_cnt <= e_div ? DIV_CNT : MULT_CNT;
      else if (md_cnt != 5'd0)
        md_cnt <= md_cnt - 5'd1;
    end
  end

endmodule
